// File: rtl/back_end_mc.sv
// Multi-channel output back end: shared IDLE/WORK controller, per-channel write strobes, address counters, full and sticky overflow.
// Strobes are combinational with wr (zero latency); addr/count/ovf are registered; a full channel drops writes and flags ovf.
module back_end_mc #(
   parameter int N_CH   = 2,
   parameter int ADDR_W = 10,
   parameter int WRAP   = 0
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic                         start,
   input  logic                         done,
   input  logic [N_CH-1:0]              wr,
   input  logic [N_CH*(ADDR_W+1)-1:0]   size,
   output logic [N_CH-1:0]              en,
   output logic [N_CH-1:0]              wren,
   output logic [N_CH*ADDR_W-1:0]       addr,
   output logic [N_CH-1:0]              full,
   output logic [N_CH-1:0]              ovf,
   output logic                         busy,
   output logic [N_CH*(ADDR_W+1)-1:0]   count
);

   localparam int CW = ADDR_W + 1;
   localparam logic [CW-1:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   typedef enum logic {IDLE, WORK} state_t;

   state_t state, state_nxt;
   logic   load;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = WORK;
               load      = 1'b1;
            end
         end
         WORK: begin
            busy = 1'b1;
            if (!start || done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
      logic [CW-1:0]     size_in;
      logic [CW-1:0]     size_eff;
      logic [CW-1:0]     size_r;
      logic [CW-1:0]     cnt;
      logic [ADDR_W-1:0] ptr;
      logic              full_c;
      logic              acc;
      logic              ovf_r;

      assign size_in = size[ch*CW +: CW];

      // Budgets beyond the buffer depth are clamped; in circular mode 0 means a full buffer.
      always_comb begin
         size_eff = size_in;
         if (size_in > DEPTH) begin
            size_eff = DEPTH;
         end
         if ((WRAP != 0) && (size_in == '0)) begin
            size_eff = DEPTH;
         end
      end

      assign full_c = busy ? ((WRAP != 0) ? 1'b0 : (cnt >= size_r)) : 1'b1;
      assign acc    = busy & wr[ch] & ~full_c;

      always_ff @(posedge aclk or posedge areset) begin
         if (areset) begin
            size_r <= '0;
            cnt    <= '0;
            ptr    <= '0;
            ovf_r  <= 1'b0;
         end else if (load) begin
            size_r <= size_eff;
            cnt    <= '0;
            ptr    <= '0;
            ovf_r  <= 1'b0;
         end else if (busy) begin
            if (acc) begin
               if (cnt != CNT_MAX) begin
                  cnt <= cnt + CW'(1);
               end
               if ({1'b0, ptr} == (size_r - CW'(1))) begin
                  ptr <= '0;
               end else begin
                  ptr <= ptr + ADDR_W'(1);
               end
            end
            if ((WRAP == 0) && wr[ch] && full_c) begin
               ovf_r <= 1'b1;
            end
         end
      end

      assign en[ch]                   = acc;
      assign wren[ch]                 = acc;
      assign full[ch]                 = full_c;
      assign ovf[ch]                  = ovf_r;
      assign addr[ch*ADDR_W +: ADDR_W] = (WRAP != 0) ? ptr : cnt[ADDR_W-1:0];
      assign count[ch*CW +: CW]       = cnt;
   end

endmodule

// File: tb/tb_back_end_mc.sv
// Bench for back_end_mc: a stop-at-size two-channel instance and a circular one-channel instance.
module tb_back_end_mc;

   localparam int AW = 4;
   localparam int CW = AW + 1;

   logic aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic            areset;
   logic            start0, done0;
   logic [1:0]      wr0;
   logic [2*CW-1:0] size0;
   logic [1:0]      en0, wren0, full0, ovf0;
   logic [2*AW-1:0] addr0;
   logic            busy0;
   logic [2*CW-1:0] count0;

   logic            start1, done1;
   logic [0:0]      wr1;
   logic [CW-1:0]   size1;
   logic [0:0]      en1, wren1, full1, ovf1;
   logic [AW-1:0]   addr1;
   logic            busy1;
   logic [CW-1:0]   count1;

   int n_chk = 0;
   int n_err = 0;
   int qa0[$];
   int qa1[$];
   int qb0[$];

   back_end_mc #(.N_CH(2), .ADDR_W(AW), .WRAP(0)) u_stop (
      .aclk(aclk), .areset(areset), .start(start0), .done(done0), .wr(wr0), .size(size0),
      .en(en0), .wren(wren0), .addr(addr0), .full(full0), .ovf(ovf0), .busy(busy0), .count(count0)
   );

   back_end_mc #(.N_CH(1), .ADDR_W(AW), .WRAP(1)) u_wrap (
      .aclk(aclk), .areset(areset), .start(start1), .done(done1), .wr(wr1), .size(size1),
      .en(en1), .wren(wren1), .addr(addr1), .full(full1), .ovf(ovf1), .busy(busy1), .count(count1)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // Scoreboard: every observed strobe must match the next expected address.
   always @(negedge aclk) begin
      if (!areset) begin
         if (wren0[0]) begin
            if (qa0.size() == 0) check("s0c0_extra_wren", 32'(wren0[0]), 32'd0);
            else                 check("s0c0_addr", 32'(addr0[AW-1:0]), 32'(qa0.pop_front()));
         end
         if (wren0[1]) begin
            if (qa1.size() == 0) check("s0c1_extra_wren", 32'(wren0[1]), 32'd0);
            else                 check("s0c1_addr", 32'(addr0[2*AW-1:AW]), 32'(qa1.pop_front()));
         end
         if (wren1[0]) begin
            if (qb0.size() == 0) check("w_extra_wren", 32'(wren1[0]), 32'd0);
            else                 check("w_addr", 32'(addr1), 32'(qb0.pop_front()));
         end
         check("s0_en_eq_wren", 32'(en0), 32'(wren0));
         check("w_en_eq_wren", 32'(en1), 32'(wren1));
      end
   end

   task automatic check_queues(input string tag);
      check({tag, "_q0"}, 32'(qa0.size()), 32'd0);
      check({tag, "_q1"}, 32'(qa1.size()), 32'd0);
      check({tag, "_qw"}, 32'(qb0.size()), 32'd0);
   endtask

   initial begin
      areset = 1'b1;
      start0 = 1'b0; done0 = 1'b0; wr0 = 2'b11; size0 = '0;
      start1 = 1'b0; done1 = 1'b0; wr1 = 1'b1;  size1 = '0;

      // reset state with writes requested
      @(negedge aclk);
      check("rst_en",    32'(en0),    32'd0);
      check("rst_wren",  32'(wren0),  32'd0);
      check("rst_full",  32'(full0),  32'h3);
      check("rst_addr",  32'(addr0),  32'd0);
      check("rst_count", 32'(count0), 32'd0);
      check("rst_busy",  32'(busy0),  32'd0);
      check("rst_ovf",   32'(ovf0),   32'd0);
      check("rst_w_wren", 32'(wren1), 32'd0);
      check("rst_w_full", 32'(full1), 32'd1);
      @(posedge aclk); #1;
      areset = 1'b0; wr0 = 2'b00; wr1 = 1'b0;
      tick();

      // size {4,2}, five writes on both channels
      size0 = {5'd2, 5'd4}; start0 = 1'b1;
      tick();
      for (int j = 0; j < 4; j++) qa0.push_back(j);
      for (int j = 0; j < 2; j++) qa1.push_back(j);
      wr0 = 2'b11;
      for (int j = 0; j < 5; j++) begin
         @(negedge aclk);
         check("t1_busy",  32'(busy0),   32'd1);
         check("t1_full0", 32'(full0[0]), 32'(j >= 4));
         check("t1_full1", 32'(full0[1]), 32'(j >= 2));
         check("t1_ovf0",  32'(ovf0[0]),  32'd0);
         check("t1_ovf1",  32'(ovf0[1]),  32'(j >= 3));
         tick();
      end
      wr0 = 2'b00;
      @(negedge aclk);
      check("t1_ovf_end",   32'(ovf0),   32'h3);
      check("t1_count_end", 32'(count0), 32'({5'd2, 5'd4}));
      start0 = 1'b0;
      tick();
      @(negedge aclk);
      check("t1_idle_busy",  32'(busy0),  32'd0);
      check("t1_idle_count", 32'(count0), 32'({5'd2, 5'd4}));
      check("t1_idle_full",  32'(full0),  32'h3);
      check_queues("t1");
      tick();

      // done together with a write; ch1 has a zero budget
      size0 = {5'd0, 5'd8}; start0 = 1'b1;
      tick();
      wr0 = 2'b11; qa0.push_back(0); qa0.push_back(1);
      for (int j = 0; j < 2; j++) begin
         @(negedge aclk);
         check("t2_zero_full", 32'(full0[1]), 32'd1);
         tick();
      end
      done0 = 1'b1; qa0.push_back(2);
      @(negedge aclk);
      check("t2_done_wren", 32'(wren0), 32'h1);
      tick();
      done0 = 1'b0; start0 = 1'b0; wr0 = 2'b00;
      @(negedge aclk);
      check("t2_busy",   32'(busy0),        32'd0);
      check("t2_count0", 32'(count0[CW-1:0]), 32'd3);
      check("t2_count1", 32'(count0[2*CW-1:CW]), 32'd0);
      check("t2_ovf",    32'(ovf0),         32'h2);
      check_queues("t2");
      tick();

      // six writes, idle hold, restart; ch1 budget clamped to depth
      size0 = {5'd20, 5'd5}; start0 = 1'b1;
      tick();
      wr0 = 2'b11;
      for (int j = 0; j < 5; j++) qa0.push_back(j);
      for (int j = 0; j < 6; j++) qa1.push_back(j);
      for (int j = 0; j < 6; j++) begin
         @(negedge aclk);
         tick();
      end
      wr0 = 2'b00; start0 = 1'b0;
      tick();
      wr0 = 2'b11;
      for (int j = 0; j < 3; j++) begin
         @(negedge aclk);
         check("t3_hold_count0", 32'(count0[CW-1:0]),     32'd5);
         check("t3_hold_count1", 32'(count0[2*CW-1:CW]),  32'd6);
         check("t3_hold_addr0",  32'(addr0[AW-1:0]),      32'd5);
         check("t3_hold_addr1",  32'(addr0[2*AW-1:AW]),   32'd6);
         check("t3_hold_wren",   32'(wren0),              32'd0);
         check("t3_hold_ovf",    32'(ovf0),               32'h1);
         tick();
      end
      wr0 = 2'b00; size0 = {5'd2, 5'd2}; start0 = 1'b1;
      tick();
      @(negedge aclk);
      check("t3_rs_count", 32'(count0), 32'd0);
      check("t3_rs_addr",  32'(addr0),  32'd0);
      check("t3_rs_ovf",   32'(ovf0),   32'd0);
      check("t3_rs_busy",  32'(busy0),  32'd1);
      check("t3_rs_full",  32'(full0),  32'd0);
      check_queues("t3");
      start0 = 1'b0;
      tick();

      // oversize budget on ch1, then start held through done
      size0 = {5'd31, 5'd2}; start0 = 1'b1;
      tick();
      wr0 = 2'b10;
      for (int j = 0; j < 16; j++) qa1.push_back(j);
      for (int j = 0; j < 17; j++) begin
         @(negedge aclk);
         check("t4_full1", 32'(full0[1]), 32'(j >= 16));
         tick();
      end
      wr0 = 2'b00;
      @(negedge aclk);
      check("t4_ovf1",   32'(ovf0[1]),            32'd1);
      check("t4_count1", 32'(count0[2*CW-1:CW]),  32'd16);
      done0 = 1'b1;
      tick();
      @(negedge aclk);
      check("t4_done_busy",  32'(busy0),             32'd0);
      check("t4_done_count", 32'(count0[2*CW-1:CW]), 32'd16);
      done0 = 1'b0;
      tick();
      @(negedge aclk);
      check("t4_reenter_busy",  32'(busy0),  32'd1);
      check("t4_reenter_count", 32'(count0), 32'd0);
      check("t4_reenter_ovf",   32'(ovf0),   32'd0);
      check_queues("t4");
      start0 = 1'b0;
      tick();

      // circular mode, size 3 then size 0
      size1 = 5'd3; start1 = 1'b1;
      tick();
      wr1 = 1'b1;
      for (int j = 0; j < 7; j++) qb0.push_back(j % 3);
      for (int j = 0; j < 7; j++) begin
         @(negedge aclk);
         check("t5_full", 32'(full1), 32'd0);
         tick();
      end
      wr1 = 1'b0;
      @(negedge aclk);
      check("t5_count", 32'(count1), 32'd7);
      check("t5_ovf",   32'(ovf1),   32'd0);
      start1 = 1'b0;
      tick();
      size1 = 5'd0; start1 = 1'b1;
      tick();
      wr1 = 1'b1;
      for (int j = 0; j < 17; j++) qb0.push_back(j % 16);
      for (int j = 0; j < 17; j++) begin
         @(negedge aclk);
         tick();
      end
      wr1 = 1'b0;
      @(negedge aclk);
      check("t5_z_count", 32'(count1), 32'd17);
      check("t5_z_ovf",   32'(ovf1),   32'd0);
      check_queues("t5");
      start1 = 1'b0;
      tick();

      // asynchronous reset in the middle of a run
      size0 = {5'd4, 5'd4}; start0 = 1'b1;
      tick();
      wr0 = 2'b11;
      qa0.push_back(0); qa0.push_back(1); qa1.push_back(0); qa1.push_back(1);
      for (int j = 0; j < 2; j++) begin
         @(negedge aclk);
         tick();
      end
      areset = 1'b1;
      #1;
      check("t6_wren",  32'(wren0),  32'd0);
      check("t6_en",    32'(en0),    32'd0);
      check("t6_busy",  32'(busy0),  32'd0);
      check("t6_count", 32'(count0), 32'd0);
      check("t6_addr",  32'(addr0),  32'd0);
      check("t6_full",  32'(full0),  32'h3);
      check("t6_ovf",   32'(ovf0),   32'd0);
      @(negedge aclk);
      check("t6_hold_wren", 32'(wren0), 32'd0);
      tick();
      areset = 1'b0; start0 = 1'b0; wr0 = 2'b00;
      tick();
      check_queues("t6");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
